// File: rtl/wb2core_no_ifs_pkg.sv
// Shared Wishbone widths, the drain-state encoding and the pending-counter width helper.
package wb_pkg;
  localparam int WB_ADR_W = 28;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} drain_st_e;

  // Must hold 0..MAX_OUTSTANDING inclusive.
  function automatic int pend_cnt_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction
endpackage

// File: rtl/wb2core_no_ifs_if.sv
// Wishbone pipelined slave side plus Ibex-style device side of the bridge.
interface wb2core_no_ifs_if;
  import wb_pkg::*;

  logic                wb_cyc_i;
  logic                wb_stb_i;
  logic                wb_we_i;
  logic [WB_ADR_W-1:0] wb_adr_i;
  logic [WB_SEL_W-1:0] wb_sel_i;
  logic [WB_DAT_W-1:0] wb_dat_i;
  logic                wb_stall_o;
  logic                wb_ack_o;
  logic                wb_err_o;
  logic [WB_DAT_W-1:0] wb_dat_o;
  logic                dev_req_o;
  logic                dev_gnt_i;
  logic                dev_we_o;
  logic [WB_SEL_W-1:0] dev_be_o;
  logic [31:0]         dev_addr_o;
  logic [WB_DAT_W-1:0] dev_wdata_o;
  logic                dev_rvalid_i;
  logic                dev_err_i;
  logic [WB_DAT_W-1:0] dev_rdata_i;

  // The bridge itself.
  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_stall_o, wb_ack_o, wb_err_o, wb_dat_o,
    output dev_req_o, dev_we_o, dev_be_o, dev_addr_o, dev_wdata_o,
    input  dev_gnt_i, dev_rvalid_i, dev_err_i, dev_rdata_i
  );

  // The Wishbone master together with the device it reaches.
  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_stall_o, wb_ack_o, wb_err_o, wb_dat_o,
    input  dev_req_o, dev_we_o, dev_be_o, dev_addr_o, dev_wdata_o,
    output dev_gnt_i, dev_rvalid_i, dev_err_i, dev_rdata_i
  );
endinterface

// File: rtl/wb2core_pend_tracker.sv
// Outstanding-request counter and RUN/DRAIN flag for orphaned responses after an abort.
module wb2core_pend_tracker
  import wb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic accept,
  input  logic rvalid,
  input  logic cyc,
  output logic full,
  output logic abort_q,
  output logic pending_nz
);
  localparam int PW = pend_cnt_w(MAX_OUTSTANDING);

  logic [PW-1:0] pending, pending_d;
  drain_st_e     state_q, state_d;
  logic          dec;

  assign pending_nz = (pending != '0);
  // A response with nothing outstanding is a protocol violation and is dropped.
  assign dec        = rvalid & pending_nz;
  assign full       = (pending == PW'(MAX_OUTSTANDING));
  assign abort_q    = (state_q == DRAIN);

  always_comb begin
    pending_d = pending;
    if (accept & ~dec)      pending_d = pending + 1'b1;
    else if (dec & ~accept) pending_d = pending - 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (!cyc && pending_d != '0) state_d = DRAIN;
      DRAIN:   if (pending_d == '0)         state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      state_q <= RUN;
    end else begin
      pending <= pending_d;
      state_q <= state_d;
    end
  end
endmodule

// File: rtl/wb2core_no_ifs.sv
// Wishbone pipelined slave driving an Ibex-style req/gnt/rvalid device port.
module wb2core_no_ifs
  import wb_pkg::*;
#(
  parameter int         MAX_OUTSTANDING = 2,
  parameter logic [1:0] ADDR_HI         = 2'b00
) (
  input logic             clk,
  input logic             rst,
  wb2core_no_ifs_if.slave bus
);
  logic                full, abort_q, pending_nz;
  logic                req, accept, fwd;
  logic                ack_q, err_q;
  logic [WB_DAT_W-1:0] dat_q;

  wb2core_pend_tracker #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_trk (
    .clk        (clk),
    .rst        (rst),
    .accept     (accept),
    .rvalid     (bus.dev_rvalid_i),
    .cyc        (bus.wb_cyc_i),
    .full       (full),
    .abort_q    (abort_q),
    .pending_nz (pending_nz)
  );

  assign req    = bus.wb_cyc_i & bus.wb_stb_i & ~full & ~abort_q;
  assign accept = req & bus.dev_gnt_i;

  assign bus.dev_req_o   = req;
  assign bus.dev_we_o    = bus.wb_we_i;
  assign bus.dev_be_o    = bus.wb_sel_i;
  assign bus.dev_wdata_o = bus.wb_dat_i;
  assign bus.dev_addr_o  = {ADDR_HI, bus.wb_adr_i, 2'b00};
  assign bus.wb_stall_o  = full | abort_q | (bus.wb_cyc_i & bus.wb_stb_i & ~bus.dev_gnt_i);

  // Responses while draining, or once the master has dropped cyc, are swallowed.
  assign fwd = bus.dev_rvalid_i & pending_nz & bus.wb_cyc_i & ~abort_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= fwd & ~bus.dev_err_i;
      err_q <= fwd & bus.dev_err_i;
      if (bus.dev_rvalid_i) dat_q <= bus.dev_rdata_i;
    end
  end

  assign bus.wb_ack_o = ack_q;
  assign bus.wb_err_o = err_q;
  assign bus.wb_dat_o = dat_q;
endmodule

// File: tb/tb_wb2core_no_ifs.sv
// Directed scenarios plus a randomized run against a cycle-level reference of the bridge rules.
module tb_wb2core_no_ifs;
  localparam int MAX_OUT = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  wb2core_no_ifs_if bus();

  wb2core_no_ifs #(.MAX_OUTSTANDING(MAX_OUT), .ADDR_HI(2'b00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
    bus.wb_adr_i = '0; bus.wb_sel_i = '0; bus.wb_dat_i = '0;
    bus.dev_gnt_i = 1; bus.dev_rvalid_i = 0; bus.dev_err_i = 0; bus.dev_rdata_i = '0;
  endtask

  task automatic wb_req(input logic we, input logic [27:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = we;
    bus.wb_adr_i = adr; bus.wb_sel_i = sel; bus.wb_dat_i = dat;
  endtask

  task automatic test_reset();
    rst = 1; drive_idle();
    tick(); tick();
    rst = 0; #1;
    n_tests++; if (bus.wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL rst_ack got %b exp 0", bus.wb_ack_o); end
    n_tests++; if (bus.wb_err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b exp 0", bus.wb_err_o); end
    n_tests++; if (bus.wb_dat_o !== 32'h0) begin n_fail++; $display("FAIL rst_dat got %h exp 0", bus.wb_dat_o); end
    n_tests++; if (bus.wb_stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b exp 0", bus.wb_stall_o); end
    n_tests++; if (bus.dev_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", bus.dev_req_o); end
  endtask

  task automatic test_single_read();
    tick(); wb_req(0, 28'h0000010, 4'hF, 32'h0); #1;
    n_tests++; if (bus.dev_req_o !== 1'b1) begin n_fail++; $display("FAIL rd_req got %b exp 1", bus.dev_req_o); end
    n_tests++; if (bus.dev_addr_o !== 32'h00000040) begin n_fail++; $display("FAIL rd_addr got %h exp 00000040", bus.dev_addr_o); end
    n_tests++; if (bus.wb_stall_o !== 1'b0) begin n_fail++; $display("FAIL rd_stall got %b exp 0", bus.wb_stall_o); end
    tick(); bus.wb_stb_i = 0;
    tick(); bus.dev_rvalid_i = 1; bus.dev_rdata_i = 32'hDEADBEEF; #1;
    n_tests++; if (bus.wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL rd_early_ack got %b exp 0", bus.wb_ack_o); end
    tick(); bus.dev_rvalid_i = 0; #1;
    n_tests++; if (bus.wb_ack_o !== 1'b1 || bus.wb_err_o !== 1'b0) begin n_fail++; $display("FAIL rd_ack got ack=%b err=%b exp ack=1 err=0", bus.wb_ack_o, bus.wb_err_o); end
    n_tests++; if (bus.wb_dat_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_dat got %h exp deadbeef", bus.wb_dat_o); end
    tick(); bus.wb_cyc_i = 0; #1;
    n_tests++; if (bus.wb_ack_o !== 1'b0 || bus.wb_dat_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_hold got ack=%b dat=%h exp ack=0 dat=deadbeef", bus.wb_ack_o, bus.wb_dat_o); end
    tick(); #1;
    n_tests++; if (bus.wb_stall_o !== 1'b0) begin n_fail++; $display("FAIL rd_pend_zero stall got %b exp 0", bus.wb_stall_o); end
  endtask

  task automatic test_byte_write();
    tick(); wb_req(1, 28'h0000123, 4'b0010, 32'h0000AB00); #1;
    n_tests++; if (bus.dev_be_o !== 4'b0010 || bus.dev_we_o !== 1'b1) begin n_fail++; $display("FAIL wr_be got be=%b we=%b exp be=0010 we=1", bus.dev_be_o, bus.dev_we_o); end
    n_tests++; if (bus.dev_wdata_o !== 32'h0000AB00) begin n_fail++; $display("FAIL wr_wdata got %h exp 0000ab00", bus.dev_wdata_o); end
    n_tests++; if (bus.dev_addr_o !== 32'h0000048C || bus.dev_req_o !== 1'b1) begin n_fail++; $display("FAIL wr_addr got addr=%h req=%b exp addr=0000048c req=1", bus.dev_addr_o, bus.dev_req_o); end
    tick(); bus.wb_stb_i = 0; bus.dev_rvalid_i = 1; bus.dev_rdata_i = 32'h0; #1;
    n_tests++; if (bus.wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL wr_early_ack got %b exp 0", bus.wb_ack_o); end
    tick(); bus.dev_rvalid_i = 0; #1;
    n_tests++; if (bus.wb_ack_o !== 1'b1 || bus.wb_err_o !== 1'b0) begin n_fail++; $display("FAIL wr_ack got ack=%b err=%b exp ack=1 err=0", bus.wb_ack_o, bus.wb_err_o); end
    tick(); bus.wb_cyc_i = 0; #1;
    n_tests++; if (bus.wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL wr_single_ack got %b exp 0", bus.wb_ack_o); end
  endtask

  task automatic test_pipelined_limit();
    tick(); wb_req(0, 28'h1, 4'hF, 32'h0); #1;
    n_tests++; if (bus.dev_req_o !== 1'b1 || bus.wb_stall_o !== 1'b0) begin n_fail++; $display("FAIL pl_first got req=%b stall=%b exp 1/0", bus.dev_req_o, bus.wb_stall_o); end
    tick(); bus.wb_adr_i = 28'h2; #1;
    n_tests++; if (bus.dev_req_o !== 1'b1 || bus.wb_stall_o !== 1'b0) begin n_fail++; $display("FAIL pl_second got req=%b stall=%b exp 1/0", bus.dev_req_o, bus.wb_stall_o); end
    tick(); bus.wb_adr_i = 28'h3; #1;
    n_tests++; if (bus.dev_req_o !== 1'b0 || bus.wb_stall_o !== 1'b1) begin n_fail++; $display("FAIL pl_full got req=%b stall=%b exp 0/1", bus.dev_req_o, bus.wb_stall_o); end
    tick(); bus.dev_rvalid_i = 1; bus.dev_rdata_i = 32'h11111111; #1;
    n_tests++; if (bus.dev_req_o !== 1'b0 || bus.wb_stall_o !== 1'b1) begin n_fail++; $display("FAIL pl_full_rv got req=%b stall=%b exp 0/1", bus.dev_req_o, bus.wb_stall_o); end
    tick(); bus.dev_rvalid_i = 0; #1;
    n_tests++; if (bus.wb_ack_o !== 1'b1 || bus.wb_dat_o !== 32'h11111111) begin n_fail++; $display("FAIL pl_ack1 got ack=%b dat=%h exp 1/11111111", bus.wb_ack_o, bus.wb_dat_o); end
    n_tests++; if (bus.dev_req_o !== 1'b1 || bus.wb_stall_o !== 1'b0) begin n_fail++; $display("FAIL pl_third got req=%b stall=%b exp 1/0", bus.dev_req_o, bus.wb_stall_o); end
    tick(); bus.wb_stb_i = 0; bus.dev_rvalid_i = 1; bus.dev_rdata_i = 32'h22222222; #1;
    n_tests++; if (bus.wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL pl_gap got ack=%b exp 0", bus.wb_ack_o); end
    tick(); bus.dev_rdata_i = 32'h33333333; #1;
    n_tests++; if (bus.wb_ack_o !== 1'b1 || bus.wb_dat_o !== 32'h22222222) begin n_fail++; $display("FAIL pl_ack2 got ack=%b dat=%h exp 1/22222222", bus.wb_ack_o, bus.wb_dat_o); end
    tick(); bus.dev_rvalid_i = 0; #1;
    n_tests++; if (bus.wb_ack_o !== 1'b1 || bus.wb_dat_o !== 32'h33333333) begin n_fail++; $display("FAIL pl_ack3 got ack=%b dat=%h exp 1/33333333", bus.wb_ack_o, bus.wb_dat_o); end
    tick(); bus.wb_cyc_i = 0;
    tick(); #1;
    n_tests++; if (bus.wb_stall_o !== 1'b0 || bus.wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL pl_drained got stall=%b ack=%b exp 0/0", bus.wb_stall_o, bus.wb_ack_o); end
  endtask

  task automatic test_dev_error();
    tick(); wb_req(0, 28'h5, 4'hF, 32'h0);
    tick(); bus.wb_stb_i = 0; bus.dev_rvalid_i = 1; bus.dev_err_i = 1; bus.dev_rdata_i = 32'h0BADF00D;
    tick(); bus.dev_rvalid_i = 0; bus.dev_err_i = 0; #1;
    n_tests++; if (bus.wb_err_o !== 1'b1 || bus.wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL err_resp got err=%b ack=%b exp 1/0", bus.wb_err_o, bus.wb_ack_o); end
    // Stray response with nothing outstanding: data is captured but nothing is signalled.
    tick(); bus.dev_rvalid_i = 1; bus.dev_err_i = 1; bus.dev_rdata_i = 32'h55AA55AA; #1;
    n_tests++; if (bus.wb_err_o !== 1'b0) begin n_fail++; $display("FAIL err_single got err=%b exp 0", bus.wb_err_o); end
    tick(); bus.dev_rvalid_i = 0; bus.dev_err_i = 0; #1;
    n_tests++; if (bus.wb_ack_o !== 1'b0 || bus.wb_err_o !== 1'b0 || bus.wb_dat_o !== 32'h55AA55AA) begin n_fail++; $display("FAIL stray_rv got ack=%b err=%b dat=%h exp 0/0/55aa55aa", bus.wb_ack_o, bus.wb_err_o, bus.wb_dat_o); end
    bus.wb_cyc_i = 0;
    tick(); tick(); #1;
    n_tests++; if (bus.wb_stall_o !== 1'b0) begin n_fail++; $display("FAIL stray_cnt stall got %b exp 0", bus.wb_stall_o); end
  endtask

  task automatic test_abort();
    tick(); wb_req(0, 28'h7, 4'hF, 32'h0);
    tick(); bus.wb_adr_i = 28'h8;
    tick(); bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
    tick(); wb_req(0, 28'h9, 4'hF, 32'h0); #1;
    n_tests++; if (bus.wb_stall_o !== 1'b1 || bus.dev_req_o !== 1'b0) begin n_fail++; $display("FAIL ab_block got stall=%b req=%b exp 1/0", bus.wb_stall_o, bus.dev_req_o); end
    bus.dev_rvalid_i = 1; bus.dev_rdata_i = 32'hA0A0A0A0;
    tick(); #1;
    n_tests++; if (bus.wb_ack_o !== 1'b0 || bus.wb_err_o !== 1'b0) begin n_fail++; $display("FAIL ab_swallow1 got ack=%b err=%b exp 0/0", bus.wb_ack_o, bus.wb_err_o); end
    n_tests++; if (bus.wb_stall_o !== 1'b1 || bus.dev_req_o !== 1'b0) begin n_fail++; $display("FAIL ab_still got stall=%b req=%b exp 1/0", bus.wb_stall_o, bus.dev_req_o); end
    tick(); bus.dev_rvalid_i = 0; #1;
    n_tests++; if (bus.wb_ack_o !== 1'b0 || bus.wb_err_o !== 1'b0) begin n_fail++; $display("FAIL ab_swallow2 got ack=%b err=%b exp 0/0", bus.wb_ack_o, bus.wb_err_o); end
    n_tests++; if (bus.dev_req_o !== 1'b1 || bus.wb_stall_o !== 1'b0) begin n_fail++; $display("FAIL ab_resume got req=%b stall=%b exp 1/0", bus.dev_req_o, bus.wb_stall_o); end
    tick(); bus.wb_stb_i = 0; bus.dev_rvalid_i = 1; bus.dev_rdata_i = 32'h44444444;
    tick(); bus.dev_rvalid_i = 0; #1;
    n_tests++; if (bus.wb_ack_o !== 1'b1 || bus.wb_dat_o !== 32'h44444444) begin n_fail++; $display("FAIL ab_after got ack=%b dat=%h exp 1/44444444", bus.wb_ack_o, bus.wb_dat_o); end
    // cyc drops in the very cycle the last response lands: no drain.
    tick(); wb_req(0, 28'hA, 4'hF, 32'h0);
    tick(); bus.wb_stb_i = 0; bus.wb_cyc_i = 0; bus.dev_rvalid_i = 1;
    tick(); bus.dev_rvalid_i = 0; #1;
    n_tests++; if (bus.wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL ab_edge_ack got %b exp 0", bus.wb_ack_o); end
    wb_req(0, 28'hB, 4'hF, 32'h0); #1;
    n_tests++; if (bus.dev_req_o !== 1'b1 || bus.wb_stall_o !== 1'b0) begin n_fail++; $display("FAIL ab_edge_run got req=%b stall=%b exp 1/0", bus.dev_req_o, bus.wb_stall_o); end
    tick(); bus.wb_stb_i = 0; bus.dev_rvalid_i = 1;
    tick(); bus.dev_rvalid_i = 0; bus.wb_cyc_i = 0; #1;
    n_tests++; if (bus.wb_ack_o !== 1'b1) begin n_fail++; $display("FAIL ab_edge_done got ack=%b exp 1", bus.wb_ack_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    tick(); wb_req(0, 28'h14, 4'hF, 32'h0);
    tick(); bus.wb_adr_i = 28'h15;
    tick(); bus.wb_stb_i = 0; bus.dev_rvalid_i = 1; bus.dev_rdata_i = 32'h66666666; rst = 1;
    tick(); rst = 0; bus.dev_rvalid_i = 0; bus.wb_cyc_i = 0; #1;
    n_tests++; if (bus.wb_ack_o !== 1'b0 || bus.wb_err_o !== 1'b0 || bus.wb_dat_o !== 32'h0) begin n_fail++; $display("FAIL mrst_out got ack=%b err=%b dat=%h exp 0/0/0", bus.wb_ack_o, bus.wb_err_o, bus.wb_dat_o); end
    n_tests++; if (bus.wb_stall_o !== 1'b0 || bus.dev_req_o !== 1'b0) begin n_fail++; $display("FAIL mrst_hs got stall=%b req=%b exp 0/0", bus.wb_stall_o, bus.dev_req_o); end
    tick(); #1;
    n_tests++; if (bus.wb_stall_o !== 1'b0) begin n_fail++; $display("FAIL mrst_cnt stall got %b exp 0", bus.wb_stall_o); end
    wb_req(0, 28'h16, 4'hF, 32'h0); #1;
    n_tests++; if (bus.dev_req_o !== 1'b1 || bus.wb_stall_o !== 1'b0) begin n_fail++; $display("FAIL mrst_req got req=%b stall=%b exp 1/0", bus.dev_req_o, bus.wb_stall_o); end
    tick(); bus.wb_stb_i = 0; bus.dev_rvalid_i = 1; bus.dev_rdata_i = 32'h77777777;
    tick(); bus.dev_rvalid_i = 0; #1;
    n_tests++; if (bus.wb_ack_o !== 1'b1 || bus.wb_dat_o !== 32'h77777777) begin n_fail++; $display("FAIL mrst_ack got ack=%b dat=%h exp 1/77777777", bus.wb_ack_o, bus.wb_dat_o); end
    tick(); bus.wb_cyc_i = 0;
    tick();
  endtask

  // Reference: integer outstanding count and an abort flag, updated once per cycle.
  task automatic test_random();
    int          pend = 0;
    bit          ab = 0, exp_ack = 0, exp_err = 0;
    logic [31:0] exp_dat = '0;
    bit          full, exp_req, exp_stall, acc, resp, fwd;
    int          n_acc = 0, n_fwd = 0, n_drop = 0;
    rst = 1; drive_idle();
    tick(); rst = 0;
    for (int i = 0; i < 600; i++) begin
      n_tests++; if (bus.wb_ack_o !== exp_ack || bus.wb_err_o !== exp_err) begin n_fail++; $display("FAIL rnd_resp cyc %0d got ack=%b err=%b exp %b/%b", i, bus.wb_ack_o, bus.wb_err_o, exp_ack, exp_err); end
      n_tests++; if (bus.wb_dat_o !== exp_dat) begin n_fail++; $display("FAIL rnd_dat cyc %0d got %h exp %h", i, bus.wb_dat_o, exp_dat); end
      bus.wb_cyc_i = ($urandom_range(0, 7) != 0);
      bus.wb_stb_i = ($urandom_range(0, 9) < 6);
      bus.wb_we_i = $urandom_range(0, 1);
      bus.wb_adr_i = 28'($urandom);
      bus.wb_sel_i = 4'($urandom);
      bus.wb_dat_i = $urandom;
      bus.dev_gnt_i = ($urandom_range(0, 3) != 0);
      bus.dev_rvalid_i = (pend > 0) && ($urandom_range(0, 2) == 0);
      bus.dev_err_i = ($urandom_range(0, 4) == 0);
      bus.dev_rdata_i = $urandom;
      #1;
      full = (pend == MAX_OUT);
      exp_req = bus.wb_cyc_i && bus.wb_stb_i && !full && !ab;
      exp_stall = full || ab || (bus.wb_cyc_i && bus.wb_stb_i && !bus.dev_gnt_i);
      n_tests++; if (bus.dev_req_o !== exp_req || bus.wb_stall_o !== exp_stall) begin n_fail++; $display("FAIL rnd_hs cyc %0d got req=%b stall=%b exp %b/%b", i, bus.dev_req_o, bus.wb_stall_o, exp_req, exp_stall); end
      n_tests++; if (bus.dev_addr_o !== {2'b00, bus.wb_adr_i, 2'b00} || bus.dev_be_o !== bus.wb_sel_i
                     || bus.dev_wdata_o !== bus.wb_dat_i || bus.dev_we_o !== bus.wb_we_i) begin
        n_fail++; $display("FAIL rnd_path cyc %0d got addr=%h be=%b wd=%h we=%b", i, bus.dev_addr_o, bus.dev_be_o, bus.dev_wdata_o, bus.dev_we_o);
      end
      acc = exp_req && bus.dev_gnt_i;
      resp = bus.dev_rvalid_i && (pend > 0);
      fwd = resp && bus.wb_cyc_i && !ab;
      exp_ack = fwd && !bus.dev_err_i;
      exp_err = fwd && bus.dev_err_i;
      if (bus.dev_rvalid_i) exp_dat = bus.dev_rdata_i;
      n_acc += int'(acc); n_fwd += int'(fwd); n_drop += int'(resp && !fwd);
      pend = pend + int'(acc) - int'(resp);
      ab = ab ? (pend != 0) : (!bus.wb_cyc_i && pend != 0);
      tick();
    end
    // Every accepted request was either answered, swallowed, or is still outstanding.
    n_tests++; if (n_acc != n_fwd + n_drop + pend) begin n_fail++; $display("FAIL rnd_balance got acc=%0d exp %0d", n_acc, n_fwd + n_drop + pend); end
    drive_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_read();
    test_byte_write();
    test_pipelined_limit();
    test_dev_error();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
